mem_responder: RTL

- Memory-side responder for the processor core's fetch, memRead and memWrite request channels.
- Owns a word array and answers every accepted request with a registered response one cycle later.
- Checks alignment and range, and raises RISC-V exception codes.
- Tracks the single LR/SC reservation, which drives the core's 2-bit reservation field.
- Sits between the core and main memory, replacing a purely combinational RAM model.

---
 rtl/mem_responder_if.sv | 45 ++++
 rtl/mem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the core and mem_responder.
//   Requests (core -> responder): fetch, load (with LR flag), store (with SC flag).
//   Responses (responder -> core): per-channel valid, data, 5-bit {valid, code}
//   exception, load reservation status, SC failure flag.
// Modports: master = core side, slave = responder side.
interface mem_responder_if;
  logic        in_fetch_enable;
  logic [31:0] in_fetch_address;
  logic        in_read_enable;
  logic [31:0] in_read_address;
  logic        in_read_reserve;
  logic        in_write_enable;
  logic [31:0] in_write_address;
  logic [31:0] in_write_data;
  logic        in_write_conditional;

  logic        out_fetch_valid;
  logic [31:0] out_fetch_data;
  logic [4:0]  out_fetch_exception;
  logic        out_read_valid;
  logic [31:0] out_read_data;
  logic [1:0]  out_read_reservation;
  logic [4:0]  out_read_exception;
  logic        out_write_valid;
  logic [4:0]  out_write_exception;
  logic        out_sc_fail;

  modport master (
    output in_fetch_enable, in_fetch_address,
    output in_read_enable, in_read_address, in_read_reserve,
    output in_write_enable, in_write_address, in_write_data, in_write_conditional,
    input  out_fetch_valid, out_fetch_data, out_fetch_exception,
    input  out_read_valid, out_read_data, out_read_reservation, out_read_exception,
    input  out_write_valid, out_write_exception, out_sc_fail
  );

  modport slave (
    input  in_fetch_enable, in_fetch_address,
    input  in_read_enable, in_read_address, in_read_reserve,
    input  in_write_enable, in_write_address, in_write_data, in_write_conditional,
    output out_fetch_valid, out_fetch_data, out_fetch_exception,
    output out_read_valid, out_read_data, out_read_reservation, out_read_exception,
    output out_write_valid, out_write_exception, out_sc_fail
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the core's fetch, load and store
// channels. Owns a DEPTH_WORDS x 32 array, answers every request with a
// registered response one cycle later, checks alignment/range (RISC-V codes)
// and tracks the single LR/SC reservation.
// Ports:
//   CLK   - clock, all state on rising edge
//   RESET - asynchronous active-low reset
//   bus   - mem_responder_if.slave (request inputs, response outputs)
// Optional build macro: MEM_RESPONDER_TRACE_EN prints one "[MemResponder]"
// line per request channel on each edge with a request.
//
// Reservation FSM
//   state    | meaning
//   IDLE     | no reservation held
//   RESERVED | reservation held on word res_word_q
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RESET,
  mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE = 1'b0, RESERVED = 1'b1} res_state_e;

  // 33-bit offset from the base: a borrow lands in bit 32, so any nonzero bit
  // above the array span means out of range, including wrap-around addresses.
  function automatic logic [32:0] offset(input logic [31:0] a);
    return {1'b0, a} - {1'b0, BASE_ADDR};
  endfunction

  logic [31:0] mem_q [DEPTH_WORDS];

  res_state_e  state_q, state_d, state_mid;
  logic [AW-1:0] res_word_q, res_word_d;

  logic [32:0] f_off, r_off, w_off;
  logic        f_mis, f_oor, r_mis, r_oor, w_mis, w_oor;
  logic        f_exc, r_exc, w_exc;
  logic [AW-1:0] f_idx, r_idx, w_idx;

  logic        is_sc, sc_hit, commit, lr_ok;

  logic [31:0] f_data_d, r_data_d;
  logic [4:0]  f_exc_d, r_exc_d, w_exc_d;
  logic [1:0]  r_res_d;
  logic        sc_fail_d;

  logic        f_valid_q, r_valid_q, w_valid_q, sc_fail_q;
  logic [31:0] f_data_q, r_data_q;
  logic [4:0]  f_exc_q, r_exc_q, w_exc_q;
  logic [1:0]  r_res_q;

  assign f_off = offset(bus.in_fetch_address);
  assign r_off = offset(bus.in_read_address);
  assign w_off = offset(bus.in_write_address);

  // BASE_ADDR is array-size aligned, so offset[1:0] equals addr[1:0].
  assign f_mis = |f_off[1:0];
  assign r_mis = |r_off[1:0];
  assign w_mis = |w_off[1:0];
  assign f_oor = |f_off[32:AW+2];
  assign r_oor = |r_off[32:AW+2];
  assign w_oor = |w_off[32:AW+2];
  assign f_exc = f_mis | f_oor;
  assign r_exc = r_mis | r_oor;
  assign w_exc = w_mis | w_oor;
  assign f_idx = f_off[AW+1:2];
  assign r_idx = r_off[AW+1:2];
  assign w_idx = w_off[AW+1:2];

  assign is_sc  = bus.in_write_enable & bus.in_write_conditional;
  assign sc_hit = (state_q == RESERVED) && (res_word_q == w_idx);
  assign commit = bus.in_write_enable & ~w_exc & (~bus.in_write_conditional | sc_hit);
  assign lr_ok  = bus.in_read_enable & bus.in_read_reserve & ~r_exc;
  assign sc_fail_d = is_sc & ~(~w_exc & sc_hit);

  // Store is evaluated against the reservation first, then a same-cycle LR.
  always_comb begin
    state_mid  = state_q;
    state_d    = state_q;
    res_word_d = res_word_q;
    if (bus.in_write_enable) begin
      if (bus.in_write_conditional) begin
        state_mid = IDLE;
      end else if (!w_exc && sc_hit) begin
        state_mid = IDLE;
      end
    end
    state_d = state_mid;
    if (lr_ok) begin
      state_d    = RESERVED;
      res_word_d = r_idx;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      res_word_q <= '0;
    end else begin
      state_q    <= state_d;
      res_word_q <= res_word_d;
    end
  end

  // Response datapath; a committing store forwards its data to a same-word
  // fetch/load in the same cycle.
  always_comb begin
    f_data_d = '0;
    r_data_d = '0;
    r_res_d  = 2'b00;
    if (!f_exc) begin
      f_data_d = (commit && (w_idx == f_idx)) ? bus.in_write_data : mem_q[f_idx];
    end
    if (!r_exc) begin
      r_data_d = (commit && (w_idx == r_idx)) ? bus.in_write_data : mem_q[r_idx];
      if (bus.in_read_reserve) begin
        r_res_d = 2'b01;
      end else if ((state_mid == RESERVED) && (res_word_q != r_idx)) begin
        r_res_d = 2'b10;
      end
    end
    f_exc_d = f_mis ? 5'h10 : (f_oor ? 5'h11 : 5'h00);
    r_exc_d = r_mis ? 5'h14 : (r_oor ? 5'h15 : 5'h00);
    w_exc_d = w_mis ? 5'h16 : (w_oor ? 5'h17 : 5'h00);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      f_valid_q <= 1'b0;
      f_data_q  <= '0;
      f_exc_q   <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_exc_q   <= '0;
      r_res_q   <= '0;
      w_valid_q <= 1'b0;
      w_exc_q   <= '0;
      sc_fail_q <= 1'b0;
    end else begin
      f_valid_q <= bus.in_fetch_enable;
      f_data_q  <= bus.in_fetch_enable ? f_data_d : '0;
      f_exc_q   <= bus.in_fetch_enable ? f_exc_d : '0;
      r_valid_q <= bus.in_read_enable;
      r_data_q  <= bus.in_read_enable ? r_data_d : '0;
      r_exc_q   <= bus.in_read_enable ? r_exc_d : '0;
      r_res_q   <= bus.in_read_enable ? r_res_d : '0;
      w_valid_q <= bus.in_write_enable;
      w_exc_q   <= bus.in_write_enable ? w_exc_d : '0;
      sc_fail_q <= sc_fail_d;
    end
  end

  // Array contents are intentionally not reset.
  always_ff @(posedge CLK) begin
    if (commit) begin
      mem_q[w_idx] <= bus.in_write_data;
    end
  end

  assign bus.out_fetch_valid      = f_valid_q;
  assign bus.out_fetch_data       = f_data_q;
  assign bus.out_fetch_exception  = f_exc_q;
  assign bus.out_read_valid       = r_valid_q;
  assign bus.out_read_data        = r_data_q;
  assign bus.out_read_reservation = r_res_q;
  assign bus.out_read_exception   = r_exc_q;
  assign bus.out_write_valid      = w_valid_q;
  assign bus.out_write_exception  = w_exc_q;
  assign bus.out_sc_fail          = sc_fail_q;

`ifdef MEM_RESPONDER_TRACE_EN
  always @(posedge CLK) begin
    if (RESET) begin
      if (bus.in_fetch_enable)
        $write("[MemResponder] fetch addr=%08h data=%08h exc=%02h res=%0d\n",
               bus.in_fetch_address, f_data_d, f_exc_d, state_q);
      if (bus.in_read_enable)
        $write("[MemResponder] %s addr=%08h data=%08h exc=%02h res=%0d\n",
               bus.in_read_reserve ? "lr" : "load",
               bus.in_read_address, r_data_d, r_exc_d, state_q);
      if (bus.in_write_enable)
        $write("[MemResponder] %s addr=%08h data=%08h exc=%02h res=%0d\n",
               bus.in_write_conditional ? "sc" : "store",
               bus.in_write_address, bus.in_write_data, w_exc_d, state_q);
    end
  end
`else
  // Trace output disabled; datapath identical.
`endif

endmodule
